auth_sequencer: RTL and testbench
=================================

# auth_sequencer

Top-level scheduler for the authentication initiator. It runs one complete authentication pass for a selected slot in a fixed order: GET_DIGESTS, then GET_CERTIFICATE, then CHALLENGE. For each step it drives the initiator's request inputs, closes the initiator's Ack handshake, and times the responder's answer using the initiator-reported timeout. It applies bounded retries and reports pass/fail to firmware-facing status.

## Interface
- MAX_RETRIES, 2, extra attempts allowed per phase after the first (0..3)
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- start  in  1  begin a pass; sampled only in IDLE, DONE, FAIL
- slot_sel  in  2  target slot; 2'b11 invalid
- init_ack_out  in  1  initiator Ack_out (message handed to transport)
- resp_valid  in  1  responder answer received (DIGESTS, CHALLENGE phases)
- cert_done  in  1  initiator Certification_done
- cert_failed  in  1  initiator Error_authentication_failed
- busy  in  1  responder busy indication (Error_Busy)
- current_timeout  in  32  initiator current_timeout, in clk cycles
- init_req  out  1  initiator init_req_in
- type_of_request  out  2  1=CHALLENGE, 2=DIGESTS, 3=CERTIFICATE, 0 when idle
- slot  out  2  slot to initiator (0 during DIGESTS)
- init_ack_in  out  1  initiator Ack_in, single-cycle pulse
- auth_done  out  1  pass succeeded, held
- auth_failed  out  1  pass failed, held
- fail_code  out  2  00 none, 01 timeout/busy exhausted, 10 certificate failed, 11 invalid slot
- retry_count  out  2  retries used in the current phase

## Operation
- All outputs are registered (Moore). Reset value of every output is 0. State goes to IDLE, timer to 0, retry counter to 0.
- States (one-hot): IDLE, DIG_REQ, DIG_WAIT, CERT_REQ, CERT_WAIT, CHAL_REQ, CHAL_WAIT, DONE, FAIL.
- IDLE / DONE / FAIL + start:
  - slot_sel==3 → FAIL, fail_code=11.
  - otherwise → DIG_REQ; clear auth_done, auth_failed, fail_code, retry_count; latch slot_sel.
- X_REQ: init_req=1 and type/slot driven.
  - init_ack_out → X_WAIT.
  - busy → retry path.
- X_WAIT: init_req=0. init_ack_in=1 on the first WAIT cycle only. The timer loads current_timeout on that cycle.
- DIG_WAIT: resp_valid → CERT_REQ. CHAL_WAIT: resp_valid → DONE.
- CERT_WAIT:
  - cert_done → CHAL_REQ.
  - cert_failed (any CERT state) → FAIL, code 10.
- Retry path (timer expired in WAIT, or busy in REQ/WAIT):
  - retry_count < MAX_RETRIES → increment retry_count, go to one-cycle gap with init_req=0, then re-enter the same X_REQ.
  - otherwise → FAIL, code 01.
- retry_count clears on every phase advance.
- DONE: auth_done=1. FAIL: auth_failed=1. Both hold until start or reset.
- start in any other state is ignored.

## Timing
- start at edge N → init_req=1, type=2 visible after edge N+1.
- init_ack_out seen at edge M → init_ack_in high for exactly cycle M+1..M+2.
- Timer decrements each WAIT cycle. Expiry is counter==0 with no completion that cycle. current_timeout=0 expires on the first WAIT cycle after the ack pulse.
- Completion and expiry in the same cycle: completion wins. cert_failed has priority over cert_done and over busy.
- Reset mid-pass: state returns to IDLE next edge, init_req drops, no status flags set.
- Phase-to-phase gap: init_req low for at least one cycle, so the initiator returns to its IDLE.

## Structure
- Shared package constants:
  - state encodings and SIZE_OF_STATES_SEQ
  - request codes REQ_CHALLENGE=1, REQ_DIGESTS=2, REQ_CERTIFICATE=3
  - fail codes FAIL_NONE, FAIL_TIMEOUT, FAIL_CERT, FAIL_SLOT
- Sub-module auth_timeout_timer with ports load, value[31:0], enable, expired. It is a 32-bit down counter that saturates at 0.

## Test plan
- Happy path, slot_sel=1, each phase answered 5 cycles after init_ack_out → type sequence 2,3,1 and auth_done=1, fail_code=00, three init_ack_in pulses.
- current_timeout=10, DIGESTS never answered, MAX_RETRIES=2 → three DIG_REQ attempts, auth_failed=1, fail_code=01, retry_count=2.
- cert_failed pulse in CERT_WAIT → FAIL with fail_code=10 on the next edge; CHALLENGE never requested.
- slot_sel=3 with start → auth_failed=1, fail_code=11, init_req never asserted.
- resp_valid coincident with the timer's zero cycle → phase advances, retry_count stays 0. busy once in CHAL_WAIT → one retry, then success.
- reset asserted in CERT_WAIT → all outputs 0 next cycle; a subsequent start restarts from DIGESTS.

Source files
------------

// File: rtl/auth_sequencer_pkg.sv
// Shared encodings for the authentication sequencer: one-hot states,
// initiator request codes and firmware-visible failure codes.
package auth_sequencer_pkg;

  localparam int SIZE_OF_STATES_SEQ = 9;

  typedef enum logic [SIZE_OF_STATES_SEQ-1:0] {
    ST_IDLE      = 9'b0_0000_0001,
    ST_DIG_REQ   = 9'b0_0000_0010,
    ST_DIG_WAIT  = 9'b0_0000_0100,
    ST_CERT_REQ  = 9'b0_0000_1000,
    ST_CERT_WAIT = 9'b0_0001_0000,
    ST_CHAL_REQ  = 9'b0_0010_0000,
    ST_CHAL_WAIT = 9'b0_0100_0000,
    ST_DONE      = 9'b0_1000_0000,
    ST_FAIL      = 9'b1_0000_0000
  } state_e;

  localparam logic [1:0] REQ_NONE        = 2'd0;
  localparam logic [1:0] REQ_CHALLENGE   = 2'd1;
  localparam logic [1:0] REQ_DIGESTS     = 2'd2;
  localparam logic [1:0] REQ_CERTIFICATE = 2'd3;

  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b01;
  localparam logic [1:0] FAIL_CERT    = 2'b10;
  localparam logic [1:0] FAIL_SLOT    = 2'b11;

  function automatic logic [1:0] req_type_of(input state_e s);
    case (s)
      ST_DIG_REQ,  ST_DIG_WAIT:  return REQ_DIGESTS;
      ST_CERT_REQ, ST_CERT_WAIT: return REQ_CERTIFICATE;
      ST_CHAL_REQ, ST_CHAL_WAIT: return REQ_CHALLENGE;
      default:                   return REQ_NONE;
    endcase
  endfunction

  // Request state of the phase that s belongs to (retry re-entry point).
  function automatic state_e req_state_of(input state_e s);
    case (s)
      ST_DIG_REQ,  ST_DIG_WAIT:  return ST_DIG_REQ;
      ST_CERT_REQ, ST_CERT_WAIT: return ST_CERT_REQ;
      ST_CHAL_REQ, ST_CHAL_WAIT: return ST_CHAL_REQ;
      default:                   return ST_IDLE;
    endcase
  endfunction

  function automatic state_e wait_state_of(input state_e s);
    case (s)
      ST_DIG_REQ:  return ST_DIG_WAIT;
      ST_CERT_REQ: return ST_CERT_WAIT;
      ST_CHAL_REQ: return ST_CHAL_WAIT;
      default:     return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/auth_sequencer_timer.sv
// Responder answer timer: 32-bit down counter that saturates at zero.
module auth_timeout_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] value,
  input  logic        enable,
  output logic        expired
);

  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (enable && (count_q != 32'd0)) begin
      count_q <= count_q - 32'd1;
    end
  end

  assign expired = (count_q == 32'd0);

endmodule

// File: rtl/auth_sequencer.sv
// Authentication pass scheduler: DIGESTS -> CERTIFICATE -> CHALLENGE with
// per-phase timeout/busy retries and held pass/fail status.
module auth_sequencer
  import auth_sequencer_pkg::*;
#(
  parameter int MAX_RETRIES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  slot_sel,
  input  logic        init_ack_out,
  input  logic        resp_valid,
  input  logic        cert_done,
  input  logic        cert_failed,
  input  logic        busy,
  input  logic [31:0] current_timeout,
  output logic        init_req,
  output logic [1:0]  type_of_request,
  output logic [1:0]  slot,
  output logic        init_ack_in,
  output logic        auth_done,
  output logic        auth_failed,
  output logic [1:0]  fail_code,
  output logic [1:0]  retry_count
);

  localparam logic [1:0] MAX_RETRIES_L = 2'(MAX_RETRIES);

  state_e     state_q, state_d;
  logic [1:0] retry_q, retry_d;
  logic [1:0] fail_q, fail_d;
  logic [1:0] slot_q, slot_d;
  logic       gap_q, gap_d;
  logic       first_q, first_d;
  logic       done_q, done_d;
  logic       failed_q, failed_d;

  logic       init_req_q;
  logic [1:0] type_q;
  logic [1:0] slot_out_q;
  logic       ack_in_q;

  logic       is_req, is_wait;
  logic       timer_load, timer_en, timer_expired;
  logic       expiry_hit, do_retry;

  assign is_req  = state_q inside {ST_DIG_REQ, ST_CERT_REQ, ST_CHAL_REQ};
  assign is_wait = state_q inside {ST_DIG_WAIT, ST_CERT_WAIT, ST_CHAL_WAIT};

  // The timer loads on the ack cycle, so expiry is only meaningful afterwards.
  assign timer_load = is_wait && first_q;
  assign timer_en   = is_wait && !first_q;
  assign expiry_hit = is_wait && !first_q && timer_expired;

  auth_timeout_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .value   (current_timeout),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    fail_d   = fail_q;
    slot_d   = slot_q;
    gap_d    = 1'b0;
    first_d  = 1'b0;
    done_d   = done_q;
    failed_d = failed_q;
    do_retry = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          done_d = 1'b0;
          if (slot_sel == 2'b11) begin
            state_d  = ST_FAIL;
            fail_d   = FAIL_SLOT;
            failed_d = 1'b1;
          end else begin
            state_d  = ST_DIG_REQ;
            fail_d   = FAIL_NONE;
            failed_d = 1'b0;
            retry_d  = '0;
            slot_d   = slot_sel;
          end
        end
      end
      ST_DIG_REQ, ST_CERT_REQ, ST_CHAL_REQ: begin
        if ((state_q == ST_CERT_REQ) && cert_failed) begin
          state_d  = ST_FAIL;
          fail_d   = FAIL_CERT;
          failed_d = 1'b1;
        end else if (!gap_q) begin
          if (init_ack_out) begin
            state_d = wait_state_of(state_q);
            first_d = 1'b1;
          end else if (busy) begin
            do_retry = 1'b1;
          end
        end
      end
      ST_DIG_WAIT: begin
        if (resp_valid) begin
          state_d = ST_CERT_REQ;
          retry_d = '0;
        end else if (busy || expiry_hit) begin
          do_retry = 1'b1;
        end
      end
      ST_CERT_WAIT: begin
        if (cert_failed) begin
          state_d  = ST_FAIL;
          fail_d   = FAIL_CERT;
          failed_d = 1'b1;
        end else if (cert_done) begin
          state_d = ST_CHAL_REQ;
          retry_d = '0;
        end else if (busy || expiry_hit) begin
          do_retry = 1'b1;
        end
      end
      ST_CHAL_WAIT: begin
        if (resp_valid) begin
          state_d = ST_DONE;
          retry_d = '0;
          done_d  = 1'b1;
        end else if (busy || expiry_hit) begin
          do_retry = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Retry re-enters the phase's request state with init_req held low one cycle.
    if (do_retry) begin
      if (retry_q < MAX_RETRIES_L) begin
        state_d = req_state_of(state_q);
        gap_d   = 1'b1;
        retry_d = retry_q + 2'd1;
      end else begin
        state_d  = ST_FAIL;
        fail_d   = FAIL_TIMEOUT;
        failed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      retry_q  <= '0;
      fail_q   <= FAIL_NONE;
      slot_q   <= '0;
      gap_q    <= 1'b0;
      first_q  <= 1'b0;
      done_q   <= 1'b0;
      failed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      fail_q   <= fail_d;
      slot_q   <= slot_d;
      gap_q    <= gap_d;
      first_q  <= first_d;
      done_q   <= done_d;
      failed_q <= failed_d;
    end
  end

  // Initiator-facing handshake outputs follow the current state one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_req_q <= 1'b0;
      type_q     <= REQ_NONE;
      slot_out_q <= '0;
      ack_in_q   <= 1'b0;
    end else begin
      init_req_q <= is_req && !gap_q;
      type_q     <= req_type_of(state_q);
      slot_out_q <= (state_q inside {ST_CERT_REQ, ST_CERT_WAIT, ST_CHAL_REQ, ST_CHAL_WAIT})
                    ? slot_q : 2'b00;
      ack_in_q   <= is_wait && first_q;
    end
  end

  assign init_req        = init_req_q;
  assign type_of_request = type_q;
  assign slot            = slot_out_q;
  assign init_ack_in     = ack_in_q;
  assign auth_done       = done_q;
  assign auth_failed     = failed_q;
  assign fail_code       = fail_q;
  assign retry_count     = retry_q;

endmodule

// File: tb/tb_auth_sequencer.sv
// Directed bench for auth_sequencer: happy path, timeout exhaustion,
// certificate failure, invalid slot, completion/expiry race, busy retry, reset.
module tb_auth_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, init_ack_out, resp_valid, cert_done, cert_failed, busy;
  logic [1:0]  slot_sel;
  logic [31:0] current_timeout;
  logic        init_req, init_ack_in, auth_done, auth_failed;
  logic [1:0]  type_of_request, slot, fail_code, retry_count;

  int checks = 0;
  int failures = 0;

  int         ack_cnt = 0;
  int         req_cnt = 0;
  int         chal_cnt = 0;
  logic [5:0] type_hist = 6'b0;
  logic       req_prev = 1'b0;

  auth_sequencer #(.MAX_RETRIES(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .slot_sel        (slot_sel),
    .init_ack_out    (init_ack_out),
    .resp_valid      (resp_valid),
    .cert_done       (cert_done),
    .cert_failed     (cert_failed),
    .busy            (busy),
    .current_timeout (current_timeout),
    .init_req        (init_req),
    .type_of_request (type_of_request),
    .slot            (slot),
    .init_ack_in     (init_ack_in),
    .auth_done       (auth_done),
    .auth_failed     (auth_failed),
    .fail_code       (fail_code),
    .retry_count     (retry_count)
  );

  always #5 clk = ~clk;

  // Observe ack pulses and request rises (with their type) on the falling edge.
  always @(negedge clk) begin
    if (init_ack_in === 1'b1) ack_cnt++;
    if (init_req === 1'b1 && req_prev !== 1'b1) begin
      req_cnt++;
      type_hist = {type_hist[3:0], type_of_request};
      if (type_of_request == 2'd1) chal_cnt++;
    end
    req_prev = init_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_comp(input bit cert, input logic v);
    if (cert) cert_done = v;
    else resp_valid = v;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (init_req !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_req"}, init_req, 1);
  endtask

  // Wait for a request, check it, close the Ack handshake; ends in the WAIT state.
  task automatic ack_only(input string tag, input logic [1:0] et, input logic [1:0] es,
                          input bit early, input bit cert);
    wait_req(tag);
    check({tag, "_type"}, type_of_request, et);
    check({tag, "_slot"}, slot, es);
    init_ack_out = 1'b1;
    step();
    init_ack_out = 1'b0;
    step();
    check({tag, "_ackpulse"}, init_ack_in, 1);
    if (early) set_comp(cert, 1'b1);
    step();
    set_comp(cert, 1'b0);
    check({tag, "_ackdrop"}, init_ack_in, 0);
  endtask

  task automatic run_phase(input string tag, input logic [1:0] et, input logic [1:0] es,
                           input bit early, input bit cert);
    ack_only(tag, et, es, early, cert);
    if (!early) begin
      step();
      set_comp(cert, 1'b1);
      step();
      set_comp(cert, 1'b0);
    end
  endtask

  task automatic wait_flag(input string tag, input bit want_done);
    int n = 0;
    while (((want_done ? auth_done : auth_failed) !== 1'b1) && n < 60) begin
      step();
      n++;
    end
    check(tag, want_done ? auth_done : auth_failed, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_init_req"}, init_req, 0);
    check({tag, "_type"}, type_of_request, 0);
    check({tag, "_slot"}, slot, 0);
    check({tag, "_ack_in"}, init_ack_in, 0);
    check({tag, "_done"}, auth_done, 0);
    check({tag, "_failed"}, auth_failed, 0);
    check({tag, "_code"}, fail_code, 0);
    check({tag, "_retry"}, retry_count, 0);
  endtask

  task automatic do_start(input logic [1:0] s);
    slot_sel = s;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int base_ack, base_req, base_chal;
    reset = 1'b1; start = 1'b0; slot_sel = 2'd0; init_ack_out = 1'b0;
    resp_valid = 1'b0; cert_done = 1'b0; cert_failed = 1'b0; busy = 1'b0;
    current_timeout = 32'd20;
    step();
    step();
    check_all_zero("rst");
    reset = 1'b0;

    // Happy path, slot 1
    base_ack = ack_cnt;
    base_req = req_cnt;
    do_start(2'd1);
    check("hp_req_not_yet", init_req, 0);
    step();
    check("hp_req_latency", init_req, 1);
    run_phase("hp_dig", 2'd2, 2'd0, 1'b0, 1'b0);
    run_phase("hp_cert", 2'd3, 2'd1, 1'b0, 1'b1);
    run_phase("hp_chal", 2'd1, 2'd1, 1'b0, 1'b0);
    wait_flag("hp_done", 1'b1);
    check("hp_failed", auth_failed, 0);
    check("hp_code", fail_code, 2'b00);
    check("hp_ack_pulses", ack_cnt - base_ack, 3);
    check("hp_req_count", req_cnt - base_req, 3);
    check("hp_type_seq", type_hist, 6'b10_11_01);

    // DIGESTS never answered: three attempts then timeout failure
    current_timeout = 32'd10;
    base_req = req_cnt;
    do_start(2'd0);
    check("to_done_cleared", auth_done, 0);
    repeat (3) ack_only("to_dig", 2'd2, 2'd0, 1'b0, 1'b0);
    wait_flag("to_failed", 1'b0);
    check("to_code", fail_code, 2'b01);
    check("to_retry", retry_count, 2);
    check("to_attempts", req_cnt - base_req, 3);
    check("to_type_seq", type_hist, 6'b10_10_10);

    // Certificate failure in CERT_WAIT
    current_timeout = 32'd20;
    base_chal = chal_cnt;
    do_start(2'd2);
    check("cf_failed_cleared", auth_failed, 0);
    run_phase("cf_dig", 2'd2, 2'd0, 1'b0, 1'b0);
    ack_only("cf_cert", 2'd3, 2'd2, 1'b0, 1'b1);
    cert_failed = 1'b1;
    step();
    cert_failed = 1'b0;
    check("cf_failed", auth_failed, 1);
    check("cf_code", fail_code, 2'b10);
    repeat (6) step();
    check("cf_no_chal", chal_cnt - base_chal, 0);
    check("cf_req_low", init_req, 0);

    // Invalid slot
    base_req = req_cnt;
    do_start(2'd3);
    check("is_failed", auth_failed, 1);
    check("is_code", fail_code, 2'b11);
    repeat (5) step();
    check("is_no_req", req_cnt - base_req, 0);
    check("is_type", type_of_request, 0);

    // Completion on the timer's zero cycle, then one busy retry in CHALLENGE
    current_timeout = 32'd0;
    do_start(2'd1);
    check("co_code_cleared", fail_code, 2'b00);
    run_phase("co_dig", 2'd2, 2'd0, 1'b1, 1'b0);
    check("co_dig_retry", retry_count, 0);
    run_phase("co_cert", 2'd3, 2'd1, 1'b1, 1'b1);
    check("co_cert_retry", retry_count, 0);
    current_timeout = 32'd20;
    base_req = req_cnt;
    ack_only("bz_chal", 2'd1, 2'd1, 1'b0, 1'b0);
    busy = 1'b1;
    step();
    busy = 1'b0;
    check("bz_retry", retry_count, 1);
    check("bz_not_failed", auth_failed, 0);
    run_phase("bz_chal2", 2'd1, 2'd1, 1'b0, 1'b0);
    wait_flag("bz_done", 1'b1);
    check("bz_code", fail_code, 2'b00);
    check("bz_retry_cleared", retry_count, 0);
    check("bz_req_count", req_cnt - base_req, 2);

    // Reset in CERT_WAIT, then restart from DIGESTS
    do_start(2'd1);
    run_phase("rs_dig", 2'd2, 2'd0, 1'b0, 1'b0);
    ack_only("rs_cert", 2'd3, 2'd1, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("rs");
    do_start(2'd2);
    step();
    check("rs_restart_req", init_req, 1);
    check("rs_restart_type", type_of_request, 2'd2);
    check("rs_restart_slot", slot, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
